// File: rtl/laser_spot_finder_pkg.sv
// laser_spot_finder_pkg: shared RGB332 field positions, frame geometry defaults, datapath widths and FSM states.
package laser_spot_finder_pkg;
  localparam int H_RES_D = 160;
  localparam int V_RES_D = 120;
  localparam int SUM_W = 22;
  localparam int CNT_W = 15;
  localparam int DIV_CYCLES = 22;
  localparam int R_HI = 7, R_LO = 5, G_HI = 4, G_LO = 2, B_HI = 1, B_LO = 0;
  typedef enum logic [1:0] {IDLE, DIVX, DIVY, DONE} state_t;
  function automatic logic is_hit(input logic [7:0] p, input int red_min, input int green_max, input int blue_max);
    return int'(p[R_HI:R_LO]) >= red_min && int'(p[G_HI:G_LO]) <= green_max && int'(p[B_HI:B_LO]) <= blue_max;
  endfunction
endpackage

// File: rtl/laser_spot_finder_seq_divider.sv
// laser_spot_finder_seq_divider: restoring divider, one quotient bit per cycle.
// The first step happens on the start edge itself, so done rises exactly DIV_CYCLES cycles after start.
module laser_spot_finder_seq_divider
  import laser_spot_finder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);
  logic [CNT_W-1:0] rem, dvs, cur_rem, cur_dvs;
  logic [SUM_W-1:0] cur_q;
  logic [CNT_W:0] sh;
  logic [CNT_W+1:0] diff;
  logic [4:0] left;
  always_comb begin
    cur_q = start ? dividend : quotient;
    cur_rem = start ? '0 : rem;
    cur_dvs = start ? divisor : dvs;
    sh = {cur_rem, cur_q[SUM_W-1]};
    diff = {1'b0, sh} - {2'b0, cur_dvs};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient <= '0;
      rem <= '0;
      dvs <= '0;
      left <= '0;
      done <= 1'b0;
    end else begin
      done <= !start && left == 5'd1;
      if (start || left != 5'd0) begin
        quotient <= {cur_q[SUM_W-2:0], ~diff[CNT_W+1]};
        rem <= diff[CNT_W+1] ? sh[CNT_W-1:0] : diff[CNT_W-1:0];
        dvs <= cur_dvs;
        left <= start ? 5'(DIV_CYCLES - 1) : left - 5'd1;
      end
    end
  end
endmodule

// File: rtl/laser_spot_finder.sv
// laser_spot_finder: thresholds the capture pixel stream for laser-red and reports one centroid per frame.
// Define SPOT_BBOX_EN to add per-frame hit bounding-box outputs latched with spot_valid.
module laser_spot_finder
  import laser_spot_finder_pkg::*;
#(
  parameter int H_RES     = H_RES_D,
  parameter int V_RES     = V_RES_D,
  parameter int RED_MIN   = 6,
  parameter int GREEN_MAX = 3,
  parameter int BLUE_MAX  = 1,
  parameter int MIN_PIX   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cam_vsync,
  input  logic       capture_we,
  input  logic [7:0] capture_data,
  output logic [7:0] spot_x,
  output logic [6:0] spot_y,
  output logic       spot_found,
  output logic       spot_valid,
  output logic       busy,
  output logic       overrun
`ifdef SPOT_BBOX_EN
  ,
  output logic [7:0] bbox_xmin,
  output logic [7:0] bbox_xmax,
  output logic [6:0] bbox_ymin,
  output logic [6:0] bbox_ymax
`endif
);
  state_t state, state_nx;
  logic [2:0] vs_sr;
  logic [7:0] x, qx, qx_c;
  logic [6:0] y, qy_c;
  logic [SUM_W-1:0] sum_x, sum_y, snap_y, quot, dividend;
  logic [CNT_W-1:0] cnt, snap_cnt, divisor;
  logic frame_end, accept, hit, div_start, div_done;
  always_comb begin
    frame_end = vs_sr[1] & ~vs_sr[2];
    accept = frame_end && state == IDLE;
    hit = capture_we && !vs_sr[1] && is_hit(capture_data, RED_MIN, GREEN_MAX, BLUE_MAX) && cnt != '1;
    div_start = accept || (state == DIVX && div_done);
    dividend = state == IDLE ? sum_x : snap_y;
    divisor = state == IDLE ? cnt : snap_cnt;
    qx_c = quot > SUM_W'(H_RES - 1) ? 8'(H_RES - 1) : quot[7:0];
    qy_c = quot > SUM_W'(V_RES - 1) ? 7'(V_RES - 1) : quot[6:0];
    state_nx = state == IDLE ? (accept ? DIVX : IDLE) :
               state == DIVX ? (div_done ? DIVY : DIVX) :
               state == DIVY ? (div_done ? DONE : DIVY) : IDLE;
    busy = state != IDLE;
    spot_valid = state == DONE;
    overrun = frame_end && busy;
  end
  laser_spot_finder_seq_divider u_div (
    .clk(clk), .rst_n(rst_n), .start(div_start), .dividend(dividend),
    .divisor(divisor), .quotient(quot), .done(div_done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vs_sr <= '0;
      x <= '0;
      y <= '0;
    end else begin
      state <= state_nx;
      vs_sr <= {vs_sr[1:0], cam_vsync};
      if (vs_sr[1]) begin
        x <= '0;
        y <= '0;
      end else if (capture_we) begin
        x <= x == 8'(H_RES - 1) ? 8'd0 : x + 8'd1;
        if (x == 8'(H_RES - 1) && y != 7'(V_RES - 1)) y <= y + 7'd1;
      end
    end
  end
  // Accumulators clear on every frame end, even one dropped for overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x <= '0;
      sum_y <= '0;
      cnt <= '0;
      snap_y <= '0;
      snap_cnt <= '0;
      qx <= '0;
      spot_x <= '0;
      spot_y <= '0;
      spot_found <= 1'b0;
    end else begin
      if (frame_end) begin
        sum_x <= '0;
        sum_y <= '0;
        cnt <= '0;
      end else if (hit) begin
        sum_x <= sum_x + SUM_W'(x);
        sum_y <= sum_y + SUM_W'(y);
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        snap_y <= sum_y;
        snap_cnt <= cnt;
      end
      if (state == DIVX && div_done) qx <= qx_c;
      if (state == DIVY && div_done) begin
        spot_found <= snap_cnt >= CNT_W'(MIN_PIX);
        if (snap_cnt >= CNT_W'(MIN_PIX)) begin
          spot_x <= qx;
          spot_y <= qy_c;
        end
      end
    end
  end
`ifdef SPOT_BBOX_EN
  logic [7:0] bx_min, bx_max, sbx_min, sbx_max;
  logic [6:0] by_min, by_max, sby_min, sby_max;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {bx_min, bx_max, by_min, by_max} <= '0;
      {sbx_min, sbx_max, sby_min, sby_max} <= '0;
      {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} <= '0;
    end else begin
      if (frame_end) {bx_min, bx_max, by_min, by_max} <= '0;
      else if (hit) begin
        bx_min <= (cnt == '0 || x < bx_min) ? x : bx_min;
        bx_max <= (cnt == '0 || x > bx_max) ? x : bx_max;
        by_min <= (cnt == '0 || y < by_min) ? y : by_min;
        by_max <= (cnt == '0 || y > by_max) ? y : by_max;
      end
      if (accept) {sbx_min, sbx_max, sby_min, sby_max} <= {bx_min, bx_max, by_min, by_max};
      if (state == DIVY && div_done) {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax} <= {sbx_min, sbx_max, sby_min, sby_max};
    end
  end
`endif
endmodule

// File: tb/tb_laser_spot_finder.sv
// tb_laser_spot_finder: directed and random frames checked against a centroid reference model.
module tb_laser_spot_finder;
  logic clk = 1'b0, rst_n = 1'b0, cam_vsync = 1'b0, capture_we = 1'b0;
  logic [7:0] capture_data = 8'd0;
  logic [7:0] spot_x;
  logic [6:0] spot_y;
  logic spot_found, spot_valid, busy, overrun;
  int compared = 0, mismatched = 0;
  logic [7:0] pix [0:19199];
  int npix = 0;
  int exp_x = 0, exp_y = 0, exp_f = 0;

  laser_spot_finder dut (
    .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .capture_we(capture_we),
    .capture_data(capture_data), .spot_x(spot_x), .spot_y(spot_y), .spot_found(spot_found),
    .spot_valid(spot_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_pix();
    if ($urandom_range(0, 2) == 0)
      return {3'($urandom_range(6, 7)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 1))};
    return 8'($urandom);
  endfunction

  // Centroid of every red hit in raster order; a miss keeps the previous coordinates.
  task automatic model();
    longint sx = 0, sy = 0, n = 0;
    for (int i = 0; i < npix; i++) begin
      int px = i % 160;
      int py = (i / 160 > 119) ? 119 : i / 160;
      if (pix[i][7:5] >= 3'd6 && pix[i][4:2] <= 3'd3 && pix[i][1:0] <= 2'd1) begin
        sx += px;
        sy += py;
        n++;
      end
    end
    exp_f = (n >= 4) ? 1 : 0;
    if (n >= 4) begin
      exp_x = (sx / n > 159) ? 159 : int'(sx / n);
      exp_y = (sy / n > 119) ? 119 : int'(sy / n);
    end
  endtask

  task automatic send_pixels();
    for (int i = 0; i < npix; i++) begin
      capture_we = 1'b1;
      capture_data = pix[i];
      tick();
    end
    capture_we = 1'b0;
    capture_data = 8'd0;
  endtask

  task automatic clear_pix(input int n);
    npix = n;
    for (int i = 0; i < 19200; i++) pix[i] = 8'd0;
  endtask

  task automatic random_frame();
    clear_pix($urandom_range(300, 1200));
    for (int i = 0; i < npix; i++) pix[i] = rand_pix();
    send_pixels();
  endtask

  task automatic end_frame(input string tag);
    int got = 0, vcnt = 0;
    model();
    cam_vsync = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (n == 3) chk({tag, " busy_run"}, busy, 1);
      if (n == 50) chk({tag, " busy_idle"}, busy, 0);
      if (spot_valid) begin
        vcnt++;
        if (got == 0) got = n;
        chk({tag, " x"}, spot_x, exp_x);
        chk({tag, " y"}, spot_y, exp_y);
        chk({tag, " found"}, spot_found, exp_f);
      end
      if (n == 6) cam_vsync = 1'b0;
    end
    chk({tag, " latency"}, got, 47);
    chk({tag, " valid_pulses"}, vcnt, 1);
  endtask

  initial begin
    int ov_at, ov_cnt, vcnt, vat;
    tick();
    tick();
    chk("rst x", spot_x, 0);
    chk("rst y", spot_y, 0);
    chk("rst found", spot_found, 0);
    chk("rst valid", spot_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    rst_n = 1'b1;
    tick();

    clear_pix(200);
    send_pixels();
    end_frame("zeros");

    clear_pix(61 * 160 + 82);
    for (int dy = 59; dy <= 61; dy++)
      for (int dx = 79; dx <= 81; dx++) pix[dy * 160 + dx] = 8'hE0;
    send_pixels();
    end_frame("block");
    chk("block x80", spot_x, 80);
    chk("block y60", spot_y, 60);

    clear_pix(19200);
    pix[0] = 8'hE0;
    pix[159] = 8'hE0;
    pix[119 * 160] = 8'hE0;
    pix[19199] = 8'hE0;
    send_pixels();
    end_frame("corners");
    chk("corners x79", spot_x, 79);
    chk("corners y59", spot_y, 59);

    clear_pix(400);
    for (int i = 0; i < npix; i++) pix[i] = (i % 2 == 0) ? 8'hFC : 8'hE3;
    send_pixels();
    end_frame("colour");

    for (int k = 0; k < 3; k++) begin
      random_frame();
      end_frame("random");
    end

    random_frame();
    model();
    ov_at = 0;
    ov_cnt = 0;
    vcnt = 0;
    vat = 0;
    cam_vsync = 1'b1;
    for (int n = 1; n <= 90; n++) begin
      tick();
      if (overrun) begin
        ov_cnt++;
        ov_at = n;
      end
      if (spot_valid) begin
        vcnt++;
        vat = n;
        chk("overrun x", spot_x, exp_x);
        chk("overrun y", spot_y, exp_y);
        chk("overrun found", spot_found, exp_f);
      end
      if (n == 5 || n == 25) cam_vsync = 1'b0;
      if (n == 20) cam_vsync = 1'b1;
    end
    chk("overrun pulses", ov_cnt, 1);
    chk("overrun edge", ov_at, 22);
    chk("overrun valids", vcnt, 1);
    chk("overrun latency", vat, 47);
    random_frame();
    end_frame("after_overrun");

    random_frame();
    cam_vsync = 1'b1;
    for (int n = 1; n <= 12; n++) tick();
    chk("midrst busy_before", busy, 1);
    rst_n = 1'b0;
    cam_vsync = 1'b0;
    tick();
    chk("midrst busy", busy, 0);
    chk("midrst valid", spot_valid, 0);
    chk("midrst x", spot_x, 0);
    chk("midrst y", spot_y, 0);
    chk("midrst found", spot_found, 0);
    tick();
    rst_n = 1'b1;
    exp_x = 0;
    exp_y = 0;
    vcnt = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (spot_valid) vcnt++;
    end
    chk("midrst no_valid", vcnt, 0);
    random_frame();
    end_frame("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
